resize_addr_sequencer: RTL and testbench

Sequences the per-pixel read/write traffic of the image resize datapath. After a start pulse it walks every destination pixel in raster order and computes the matching source address for the selected mode: copy, 2x nearest-neighbour zoom, or 2x decimation downscale. For each pixel it reads the source frame memory, waits the memory latency, and writes the pixel to the destination frame memory. It sits between the top-level processing FSM (start/mode/done) and the two frame memories.

---
 rtl/resize_addr_sequencer_if.sv | 40 ++++
 rtl/resize_addr_sequencer.sv | 163 ++++++++++++++++
 tb/tb_resize_addr_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/resize_addr_sequencer_if.sv
// rtl/resize_addr_sequencer_if.sv - control and frame-memory signals of the resize address sequencer
//
// Purpose: bundles the start/mode/done handshake with the processing FSM and
// the read/write ports of the source and destination frame memories.
// Ports (master = sequencer side):
//   start, mode          control inputs from the processing FSM
//   busy, done, state    status outputs
//   rd_en, rd_addr       source read strobe/address; rd_data returns RD_LAT cycles later
//   wr_en, wr_addr,
//   wr_data, wr_ready    destination write request held until wr_ready
interface resize_addr_sequencer_if #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int PIX_W  = 8,
  parameter int SRC_AW = $clog2(SRC_W * SRC_H),
  parameter int DST_AW = $clog2(4 * SRC_W * SRC_H)
);
  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic [2:0]        state;
  logic              rd_en;
  logic [SRC_AW-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              wr_en;
  logic [DST_AW-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ready;

  modport master (
    input  start, mode, rd_data, wr_ready,
    output busy, done, state, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, mode, rd_data, wr_ready,
    input  busy, done, state, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/resize_addr_sequencer.sv
// rtl/resize_addr_sequencer.sv - per-pixel source/destination address sequencer for the resize datapath
//
// Purpose: after start, walks every destination pixel in raster order, reads
// the matching source pixel (copy, 2x zoom or 2x downscale) and writes it to
// the destination frame memory, one pixel at a time.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      resize_addr_sequencer_if master modport (control + frame memories)
module resize_addr_sequencer #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 1,
  parameter int SRC_AW = $clog2(SRC_W * SRC_H),
  parameter int DST_AW = $clog2(4 * SRC_W * SRC_H)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  resize_addr_sequencer_if.master bus
);
  localparam int DX_W  = $clog2(2 * SRC_W) + 1;
  localparam int DY_W  = $clog2(2 * SRC_H) + 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);

  localparam logic [1:0] MODE_COPY = 2'b00;
  localparam logic [1:0] MODE_ZOOM = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DX_W-1:0]   dx_q, dx_d, dx_last;
  logic [DY_W-1:0]   dy_q, dy_d, dy_last;
  logic [SRC_AW-1:0] row_base_q, row_base_d, sx, row_step;
  logic [DST_AW-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              rd_en, last_pix;

  // Mode-dependent geometry. row_base tracks the source row start so no
  // multiplier is needed; zoom repeats each source row twice, so its base only
  // moves after the odd destination row.
  always_comb begin
    dx_last  = DX_W'(SRC_W - 1);
    dy_last  = DY_W'(SRC_H - 1);
    sx       = SRC_AW'(dx_q);
    row_step = SRC_AW'(SRC_W);
    case (mode_q)
      MODE_ZOOM: begin
        dx_last  = DX_W'(2 * SRC_W - 1);
        dy_last  = DY_W'(2 * SRC_H - 1);
        sx       = SRC_AW'(dx_q >> 1);
        row_step = dy_q[0] ? SRC_AW'(SRC_W) : '0;
      end
      MODE_DOWN: begin
        dx_last  = DX_W'(SRC_W / 2 - 1);
        dy_last  = DY_W'(SRC_H / 2 - 1);
        sx       = SRC_AW'({dx_q, 1'b0});
        row_step = SRC_AW'(2 * SRC_W);
      end
      default: ;
    endcase
  end

  assign last_pix = (dx_q == dx_last) && (dy_q == dy_last);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    row_base_d = row_base_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    lat_d      = lat_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Reserved mode 11 is folded into copy at the latch point.
          mode_d     = (bus.mode == 2'b11) ? MODE_COPY : bus.mode;
          dx_d       = '0;
          dy_d       = '0;
          wr_addr_d  = '0;
          row_base_d = '0;
          lat_d      = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          wr_data_d = bus.rd_data;
          state_d   = S_WRITE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (bus.wr_ready) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
            state_d   = S_ISSUE;
            if (dx_q == dx_last) begin
              dx_d       = '0;
              dy_d       = dy_q + 1'b1;
              row_base_d = row_base_q + row_step;
            end else begin
              dx_d = dx_q + 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_COPY;
      dx_q       <= '0;
      dy_q       <= '0;
      row_base_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      row_base_q <= row_base_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      lat_q      <= lat_d;
    end
  end

  assign rd_en       = (state_q == S_ISSUE);
  assign bus.rd_en   = rd_en;
  // Address is gated so the bus reads 0 outside ISSUE.
  assign bus.rd_addr = rd_en ? (row_base_q + sx) : '0;
  assign bus.wr_en   = (state_q == S_WRITE);
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.state   = state_q;
endmodule

// File: tb/tb_resize_addr_sequencer.sv
// tb/tb_resize_addr_sequencer.sv - directed self-checking bench for resize_addr_sequencer
module tb_resize_addr_sequencer;
  localparam int SRC_W  = 4;
  localparam int SRC_H  = 2;
  localparam int PIX_W  = 8;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  resize_addr_sequencer_if #(.SRC_W(SRC_W), .SRC_H(SRC_H), .PIX_W(PIX_W)) bus ();

  resize_addr_sequencer #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .PIX_W(PIX_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  // Source memory: data = address + 0x10, one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= 8'(bus.rd_addr) + 8'h10;
  end

  int n_cmp = 0;
  int n_err = 0;
  int wa_q[$];
  int wd_q[$];
  int ra_q[$];
  int done_cyc;
  int done_cnt;
  int hold_cnt;
  int hold_bad;
  int overlap = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},    32'(bus.busy),    32'd0);
    chk({tag, "_done"},    32'(bus.done),    32'd0);
    chk({tag, "_state"},   32'(bus.state),   32'd0);
    chk({tag, "_rd_en"},   32'(bus.rd_en),   32'd0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    chk({tag, "_wr_en"},   32'(bus.wr_en),   32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
  endtask

  // Runs one frame. Cycle 1 is the cycle after the start-accepting edge.
  // stall_n: wr_ready low cycles on the write to address 3.
  // restart_cyc: cycle in which a stray start pulse is driven (-1 none).
  // rst_pix: assert reset at the ISSUE of this pixel (-1 none).
  task automatic run_frame(input logic [1:0] m, input int stall_n, input int restart_cyc,
                           input int rst_pix);
    int cyc;
    int stall_left;
    bit fin;
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    done_cyc = -1; done_cnt = 0; hold_cnt = 0; hold_bad = 0;
    stall_left = stall_n;
    bus.start = 1'b1;
    bus.mode  = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode  = ~m;
    cyc = 1;
    fin = 1'b0;
    while (!fin && cyc < 400) begin
      bus.start    = (cyc == restart_cyc);
      bus.wr_ready = 1'b1;
      if (bus.wr_en && bus.wr_addr == 5'd3 && stall_n > 0) begin
        hold_cnt++;
        if (bus.wr_data != 8'h13) hold_bad++;
        if (stall_left > 0) begin
          bus.wr_ready = 1'b0;
          stall_left--;
        end
      end
      if (rst_pix >= 0 && bus.rd_en && wa_q.size() == rst_pix) begin
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        chk("midrst_writes_before", 32'(wa_q.size()), 32'd10);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          chk($sformatf("midrst_wr_en%0d", i), 32'(bus.wr_en), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("postrst_state", 32'(bus.state), 32'd0);
        fin = 1'b1;
      end else begin
        if (bus.rd_en) ra_q.push_back(int'(bus.rd_addr));
        if (bus.wr_en && bus.wr_ready) begin
          wa_q.push_back(int'(bus.wr_addr));
          wd_q.push_back(int'(bus.wr_data));
        end
        if (bus.rd_en && bus.wr_en) overlap++;
        if (bus.done) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (done_cyc >= 0 && cyc == done_cyc + 1) begin
          chk("busy_after_done", 32'(bus.busy), 32'd0);
          fin = 1'b1;
        end
        if (!fin) begin
          @(posedge clk); #1;
          cyc++;
        end
      end
    end
    bus.start    = 1'b0;
    bus.wr_ready = 1'b1;
    chk("frame_finished", 32'(fin), 32'd1);
  endtask

  task automatic check_copy(input string tag, input int exp_done);
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'd8);
    chk({tag, "_nrd"}, 32'(ra_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < wa_q.size() && i < ra_q.size(); i++) begin
      chk($sformatf("%s_wa%0d", tag, i), 32'(wa_q[i]), 32'(i));
      chk($sformatf("%s_ra%0d", tag, i), 32'(ra_q[i]), 32'(i));
      chk($sformatf("%s_wd%0d", tag, i), 32'(wd_q[i]), 32'(i + 16));
    end
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int exp_ra;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.mode     = 2'b00;
    bus.wr_ready = 1'b1;
    bus.rd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_outputs_zero("idle");

    // Copy, no stalls.
    run_frame(2'b00, 0, -1, -1);
    check_copy("copy", 25);

    // Zoom 2x: 8x4 destination, each source pixel used four times.
    run_frame(2'b01, 0, -1, -1);
    chk("zoom_nwr", 32'(wa_q.size()), 32'd32);
    chk("zoom_nrd", 32'(ra_q.size()), 32'd32);
    for (int i = 0; i < 32 && i < wa_q.size() && i < ra_q.size(); i++) begin
      exp_ra = ((i / 8) / 2) * 4 + (i % 8) / 2;
      chk($sformatf("zoom_wa%0d", i), 32'(wa_q[i]), 32'(i));
      chk($sformatf("zoom_ra%0d", i), 32'(ra_q[i]), 32'(exp_ra));
      chk($sformatf("zoom_wd%0d", i), 32'(wd_q[i]), 32'(exp_ra + 16));
    end
    chk("zoom_done_cyc", 32'(done_cyc), 32'd97);

    // Downscale 2x: 2x1 destination.
    run_frame(2'b10, 0, -1, -1);
    chk("down_nwr", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2 && ra_q.size() == 2) begin
      chk("down_ra0", 32'(ra_q[0]), 32'd0);
      chk("down_ra1", 32'(ra_q[1]), 32'd2);
      chk("down_wa0", 32'(wa_q[0]), 32'd0);
      chk("down_wa1", 32'(wa_q[1]), 32'd1);
      chk("down_wd0", 32'(wd_q[0]), 32'h10);
      chk("down_wd1", 32'(wd_q[1]), 32'h12);
    end
    chk("down_done_cyc", 32'(done_cyc), 32'd7);

    // Copy with a 5-cycle stall on pixel 3.
    run_frame(2'b00, 5, -1, -1);
    check_copy("stall", 30);
    chk("stall_hold_cycles", 32'(hold_cnt), 32'd6);
    chk("stall_hold_data_bad", 32'(hold_bad), 32'd0);

    // Reset during zoom pixel 10, then a clean downscale frame.
    run_frame(2'b01, 0, -1, 10);
    run_frame(2'b10, 0, -1, -1);
    chk("rstdown_nwr", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2 && ra_q.size() == 2) begin
      chk("rstdown_wa0", 32'(wa_q[0]), 32'd0);
      chk("rstdown_wa1", 32'(wa_q[1]), 32'd1);
      chk("rstdown_ra1", 32'(ra_q[1]), 32'd2);
      chk("rstdown_wd1", 32'(wd_q[1]), 32'h12);
    end
    chk("rstdown_done_cyc", 32'(done_cyc), 32'd7);

    // Reserved mode behaves as copy.
    run_frame(2'b11, 0, -1, -1);
    check_copy("mode11", 25);

    // Stray start mid-frame is ignored.
    run_frame(2'b00, 0, 10, -1);
    check_copy("stray", 25);

    chk("rd_wr_overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
